// File: rtl/hart_ctrl_if.sv
// Bus bundle between a hart-boot master and the hart_ctrl block.
// The platform package providing the default debug boot-ROM address comes first.
package cei_mochila_pkg;
   localparam logic [31:0] DEBUG_BOOTROM_START_ADDRESS = 32'h1A11_0000;
endpackage

interface hart_ctrl_if #(
   parameter int unsigned NHARTS = 3
);
   logic                     start_i;
   logic [NHARTS-1:0]        hart_mask_i;
   logic [NHARTS-1:0]        stop_i;
   logic [NHARTS-1:0]        core_sleep_i;
   logic [NHARTS-1:0][31:0]  irq_i;
   logic [NHARTS-1:0]        debug_req_i;
   logic [NHARTS-1:0]        fetch_enable_o;
   logic [NHARTS-1:0]        clk_en_o;
   logic [NHARTS-1:0][31:0]  boot_addr_o;
   logic [NHARTS-1:0][31:0]  hart_id_o;
   logic [NHARTS-1:0]        running_o;
   logic                     busy_o;

   modport master (
      output start_i, hart_mask_i, stop_i, core_sleep_i, irq_i, debug_req_i,
      input  fetch_enable_o, clk_en_o, boot_addr_o, hart_id_o, running_o, busy_o
   );

   modport slave (
      input  start_i, hart_mask_i, stop_i, core_sleep_i, irq_i, debug_req_i,
      output fetch_enable_o, clk_en_o, boot_addr_o, hart_id_o, running_o, busy_o
   );
endinterface

// File: rtl/hart_ctrl.sv
// Staggered multi-hart boot sequencer with per-hart run/stop control and
// sleep-driven clock gating that reopens combinationally on any wake source.
module hart_ctrl #(
   parameter int unsigned NHARTS      = 3,
   parameter logic [31:0] BOOT_ADDR   = cei_mochila_pkg::DEBUG_BOOTROM_START_ADDRESS,
   parameter logic [31:0] HARTID_BASE = 32'h0,
   parameter int unsigned STAGGER     = 4,
   parameter int unsigned SLEEP_HOLD  = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   hart_ctrl_if.slave  bus
);

   localparam int unsigned SW = (STAGGER    > 1) ? $clog2(STAGGER)    : 1;
   localparam int unsigned CW = (SLEEP_HOLD > 1) ? $clog2(SLEEP_HOLD) : 1;
   localparam logic [SW-1:0] GAP_RELOAD = SW'(STAGGER - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(SLEEP_HOLD - 1);

   typedef enum logic       {SEQ_IDLE, SEQ_STAGGER} seq_state_e;
   typedef enum logic [1:0] {HART_OFF, HART_RUN, HART_GATED} hart_state_e;

   seq_state_e        r_seq, w_seq_nxt;
   logic [NHARTS-1:0] r_pend, w_pend_nxt;
   logic [SW-1:0]     r_gap, w_gap_nxt;
   logic [NHARTS-1:0] w_pick, w_seq_en;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_seq  <= SEQ_IDLE;
         r_pend <= '0;
         r_gap  <= '0;
      end else begin
         r_seq  <= w_seq_nxt;
         r_pend <= w_pend_nxt;
         r_gap  <= w_gap_nxt;
      end
   end

   // Lowest pending hart; unmasked harts are skipped without spending a cycle.
   assign w_pick = r_pend & (~r_pend + NHARTS'(1));

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_seq_nxt  = r_seq;
      w_pend_nxt = r_pend;
      w_gap_nxt  = r_gap;
      case (r_seq)
         SEQ_IDLE: begin
            if (bus.start_i && (|bus.hart_mask_i)) begin
               w_seq_nxt  = SEQ_STAGGER;
               w_pend_nxt = bus.hart_mask_i;
               w_gap_nxt  = '0;
            end
         end
         SEQ_STAGGER: begin
            if (r_gap == '0) begin
               w_pend_nxt = r_pend & ~w_pick;
               w_gap_nxt  = GAP_RELOAD;
               if ((r_pend & ~w_pick) == '0) w_seq_nxt = SEQ_IDLE;
            end else begin
               w_gap_nxt = r_gap - SW'(1);
            end
         end
         default: w_seq_nxt = SEQ_IDLE;
      endcase
   end

   always_comb begin
      w_seq_en = '0;
      if (r_seq == SEQ_STAGGER && r_gap == '0) w_seq_en = w_pick;
   end

   assign bus.busy_o = (r_seq == SEQ_STAGGER);

   for (genvar h = 0; h < NHARTS; h++) begin : g_hart
      hart_state_e   r_st, w_st_nxt;
      logic [CW-1:0] r_cnt, w_cnt_nxt;
      logic          w_wake, w_fetch, w_run, w_clk_en;
      logic          w_unused_irq_lo;

      // Only the fast interrupt lines can pull a gated hart back.
      assign w_wake = (|bus.irq_i[h][31:16]) | bus.debug_req_i[h] | ~bus.core_sleep_i[h];
      assign w_unused_irq_lo = ^bus.irq_i[h][15:0];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_st  <= HART_OFF;
            r_cnt <= '0;
         end else begin
            r_st  <= w_st_nxt;
            r_cnt <= w_cnt_nxt;
         end
      end

      always_comb begin
         w_st_nxt  = r_st;
         w_cnt_nxt = '0;
         case (r_st)
            HART_OFF: begin
               if (w_seq_en[h] && !bus.stop_i[h]) w_st_nxt = HART_RUN;
            end
            HART_RUN: begin
               if (bus.stop_i[h]) begin
                  w_st_nxt = HART_OFF;
               end else if (bus.core_sleep_i[h]) begin
                  if (r_cnt == HOLD_LAST) w_st_nxt  = HART_GATED;
                  else                    w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            HART_GATED: begin
               if (bus.stop_i[h]) w_st_nxt = HART_OFF;
               else if (w_wake)   w_st_nxt = HART_RUN;
            end
            default: w_st_nxt = HART_OFF;
         endcase
      end

      always_comb begin
         w_fetch  = (r_st != HART_OFF);
         w_run    = (r_st == HART_RUN);
         w_clk_en = !((r_st == HART_GATED) && !w_wake);
      end

      assign bus.fetch_enable_o[h] = w_fetch;
      assign bus.running_o[h]      = w_run;
      assign bus.clk_en_o[h]       = w_clk_en;
      assign bus.boot_addr_o[h]    = BOOT_ADDR;
      assign bus.hart_id_o[h]      = HARTID_BASE + 32'(h);
   end

endmodule

// File: tb/tb_hart_ctrl.sv
// Directed and randomized bench for hart_ctrl against a schedule-based reference model.
module tb_hart_ctrl;
  localparam int          NH    = 3;
  localparam int          STG   = 4;
  localparam int          SH    = 8;
  localparam logic [31:0] HBASE = 32'hFFFF_FFFE;
  localparam int          M_OFF = 0, M_RUN = 1, M_GATED = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass   = 0;
  int   n_checks = 0;

  // Reference model: hart modes, sleep run-lengths, and the absolute edge each hart is due.
  int m_st    [NH];
  int m_cnt   [NH];
  int m_en_at [NH];
  int m_last;
  int edge_n;
  bit m_busy;

  hart_ctrl_if #(.NHARTS(NH)) bus ();

  hart_ctrl #(
    .NHARTS     (NH),
    .HARTID_BASE(HBASE),
    .STAGGER    (STG),
    .SLEEP_HOLD (SH)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic m_wake(input int h);
    return (|bus.irq_i[h][31:16]) | bus.debug_req_i[h] | ~bus.core_sleep_i[h];
  endfunction

  function automatic logic [NH-1:0] m_clk_en();
    logic [NH-1:0] v;
    for (int h = 0; h < NH; h++) v[h] = !(m_st[h] == M_GATED && !m_wake(h));
    return v;
  endfunction

  task automatic m_reset();
    for (int h = 0; h < NH; h++) begin
      m_st[h] = M_OFF; m_cnt[h] = 0; m_en_at[h] = -1;
    end
    m_last = -1;
    m_busy = 1'b0;
  endtask

  task automatic model_edge();
    int k;
    edge_n++;
    for (int h = 0; h < NH; h++) begin
      case (m_st[h])
        M_OFF: if (m_en_at[h] == edge_n && !bus.stop_i[h]) m_st[h] = M_RUN;
        M_RUN: begin
          if (bus.stop_i[h]) begin
            m_st[h] = M_OFF; m_cnt[h] = 0;
          end else if (bus.core_sleep_i[h]) begin
            m_cnt[h]++;
            if (m_cnt[h] == SH) begin m_st[h] = M_GATED; m_cnt[h] = 0; end
          end else begin
            m_cnt[h] = 0;
          end
        end
        default: begin
          if (bus.stop_i[h])  m_st[h] = M_OFF;
          else if (m_wake(h)) m_st[h] = M_RUN;
        end
      endcase
    end
    if (!m_busy && bus.start_i && bus.hart_mask_i != '0) begin
      k = 0;
      for (int h = 0; h < NH; h++) begin
        if (bus.hart_mask_i[h]) begin
          m_en_at[h] = edge_n + 1 + k * STG;
          m_last     = m_en_at[h];
          k++;
        end
      end
    end
    m_busy = (m_last > edge_n);
  endtask

  task automatic check_outputs(input string ph);
    logic [NH-1:0] ef, er;
    for (int h = 0; h < NH; h++) begin
      ef[h] = (m_st[h] != M_OFF);
      er[h] = (m_st[h] == M_RUN);
    end
    check({ph, ".fetch"},  32'(bus.fetch_enable_o), 32'(ef));
    check({ph, ".run"},    32'(bus.running_o),      32'(er));
    check({ph, ".clk_en"}, 32'(bus.clk_en_o),       32'(m_clk_en()));
    check({ph, ".busy"},   32'(bus.busy_o),         32'(m_busy));
  endtask

  // Called at a negedge with fresh inputs: peek the combinational gate, clock, then check.
  task automatic step(input string ph);
    #1;
    check({ph, ".clk_en_comb"}, 32'(bus.clk_en_o), 32'(m_clk_en()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(ph);
  endtask

  initial begin
    logic [31:0] exp_id;
    bus.start_i      = 1'b0;
    bus.hart_mask_i  = '0;
    bus.stop_i       = '0;
    bus.core_sleep_i = '0;
    bus.irq_i        = '0;
    bus.debug_req_i  = '0;
    edge_n = 0;
    m_reset();

    #1;
    check_outputs("reset");
    for (int h = 0; h < NH; h++) begin
      exp_id = HBASE + 32'(h);
      check($sformatf("boot_addr%0d", h), bus.boot_addr_o[h], cei_mochila_pkg::DEBUG_BOOTROM_START_ADDRESS);
      check($sformatf("hart_id%0d", h),   bus.hart_id_o[h],   exp_id);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full mask: enables at edges 1, 5, 9 after start.
    bus.hart_mask_i = 3'b111; bus.start_i = 1'b1;
    step("boot111");
    bus.start_i = 1'b0; bus.hart_mask_i = '0;
    repeat (12) step("boot111");

    bus.stop_i = 3'b111; step("stop_all");
    bus.stop_i = '0;     step("stop_all");

    // Sparse mask with a re-start attempt while busy.
    bus.hart_mask_i = 3'b101; bus.start_i = 1'b1;
    step("boot101");
    bus.start_i = 1'b0; bus.hart_mask_i = '0;
    repeat (2) step("boot101");
    bus.hart_mask_i = 3'b010; bus.start_i = 1'b1;
    step("restart_ignored");
    bus.start_i = 1'b0; bus.hart_mask_i = '0;
    repeat (8) step("boot101");

    // Sleep gating, slow irq does not wake, fast irq wakes combinationally.
    bus.core_sleep_i = 3'b101;
    repeat (SH) step("sleep");
    bus.irq_i[0][15] = 1'b1;
    step("slow_irq");
    bus.irq_i[0][15] = 1'b0; bus.irq_i[0][16] = 1'b1;
    step("fast_irq");
    bus.irq_i = '0;
    step("fast_irq");

    // Sleep run broken one short of the hold, then a full run gates.
    bus.core_sleep_i = 3'b000; step("wake_all");
    bus.core_sleep_i = 3'b100;
    repeat (SH - 1) step("sleep7");
    bus.core_sleep_i = 3'b000; step("sleep_break");
    bus.core_sleep_i = 3'b100;
    repeat (SH) step("sleep8");
    bus.stop_i = 3'b100; step("stop_gated");
    bus.stop_i = '0;     step("stop_gated");

    // stop_i[1] coincides with hart1's enable.
    bus.core_sleep_i = '0;
    bus.stop_i = 3'b111; step("pre_race");
    bus.stop_i = '0;
    bus.hart_mask_i = 3'b111; bus.start_i = 1'b1;
    step("race");
    bus.start_i = 1'b0; bus.hart_mask_i = '0;
    repeat (STG) step("race");
    bus.stop_i = 3'b010; step("race_stop");
    bus.stop_i = '0;
    repeat (6) step("race");

    // Random traffic against the model.
    for (int i = 0; i < 250; i++) begin
      bus.start_i     = ($urandom_range(0, 7) == 0);
      bus.hart_mask_i = NH'($urandom_range(0, 7));
      for (int h = 0; h < NH; h++) begin
        bus.stop_i[h]       = ($urandom_range(0, 29) == 0);
        bus.core_sleep_i[h] = ($urandom_range(0, 7) != 0);
        bus.debug_req_i[h]  = ($urandom_range(0, 19) == 0);
        bus.irq_i[h][15:0]  = 16'($urandom);
        bus.irq_i[h][31:16] = ($urandom_range(0, 11) == 0) ? 16'($urandom) : 16'h0;
      end
      step("rand");
    end
    bus.start_i = 1'b0; bus.stop_i = '0; bus.core_sleep_i = '0;
    bus.debug_req_i = '0; bus.irq_i = '0; bus.hart_mask_i = '0;

    // Asynchronous reset in the middle of a stagger sequence.
    bus.stop_i = 3'b111; step("pre_rst");
    bus.stop_i = '0;
    bus.hart_mask_i = 3'b111; bus.start_i = 1'b1;
    step("rst_mid");
    bus.start_i = 1'b0; bus.hart_mask_i = '0;
    repeat (2) step("rst_mid");
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_outputs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) step("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
